// File: rtl/bram_frame_writer.sv
// Streams one frame of DEPTH words into a BRAM port from address 0 upward,
// then raises done until the consumer acknowledges it.
module bram_frame_writer #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 65536
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [ADDR_W-1:0] pl_addr,
    output logic [DATA_W-1:0] pl_din,
    output logic              pl_en,
    output logic              pl_wr_en,
    output logic              done,
    input  logic              done_ack,
    output logic              busy,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] index;
    logic              hs;
    logic              last_word;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        busy      = 1'b1;
        hs        = 1'b0;
        last_word = (index == LAST_IDX);
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = FILL;
            end
            FILL: begin
                s_ready = 1'b1;
                hs      = s_valid;
                if (s_valid && last_word) state_nxt = DONE;
            end
            DONE: begin
                if (done_ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The compare-and-clear on the last word also covers DEPTH == 2^ADDR_W,
    // where it coincides with the natural overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            index      <= '0;
            word_count <= '0;
            pl_addr    <= '0;
            pl_din     <= '0;
            pl_en      <= 1'b0;
            pl_wr_en   <= 1'b0;
            done       <= 1'b0;
        end else begin
            pl_en    <= hs;
            pl_wr_en <= hs;
            if (hs) begin
                pl_addr    <= index;
                pl_din     <= s_data;
                index      <= last_word ? '0 : index + 1'b1;
                word_count <= word_count + 1'b1;
            end
            if (state == IDLE && start) begin
                index      <= '0;
                word_count <= '0;
            end
            if (hs && last_word) begin
                done <= 1'b1;
            end else if (state == DONE && done_ack) begin
                done <= 1'b0;
            end
        end
    end

endmodule

// File: doc/bram_frame_writer.md
Name: bram_frame_writer

Overview:
- PL-side writer that fills the shared dual-port BRAM with one frame of streamed data.
- Write-side counterpart of the PL address/read sequencer.
- Accepts a valid/ready data stream and issues sequential BRAM writes from address 0.
- When DEPTH words are written, raises done and holds it until acknowledged. The reader uses done to start its scan.

Parameters:
ADDR_W, 16, BRAM address width.
DATA_W, 32, BRAM / stream data width.
DEPTH, 65536, words per frame; legal range 1..2^ADDR_W.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst_n  input  1  synchronous reset, active low.
start  input  1  begin a new frame; sampled only in IDLE.
s_data  input  DATA_W  stream data word.
s_valid  input  1  s_data valid.
s_ready  output  1  writer can accept a word.
pl_addr  output  ADDR_W  BRAM write address.
pl_din  output  DATA_W  BRAM write data.
pl_en  output  1  BRAM port enable.
pl_wr_en  output  1  BRAM write enable.
done  output  1  frame complete (level).
done_ack  input  1  consumer acknowledges done; sampled only in DONE.
busy  output  1  state != IDLE.
word_count  output  ADDR_W+1  words written in current frame, 0..DEPTH.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=IDLE; internal index=0.
  - pl_addr=0, pl_din=0, pl_en=0, pl_wr_en=0, done=0, word_count=0.
  - s_ready=0, busy=0.
  - Reset mid-FILL drops any pending write: pl_en=0 after that edge, and no partial frame is resumed.
- States: IDLE, FILL, DONE. All outputs except s_ready and busy are registered. s_ready = (state==FILL); busy = (state!=IDLE).
- IDLE:
  - start=1 moves to FILL next cycle.
  - Same edge clears index and word_count to 0.
  - s_valid is ignored.
- FILL:
  - A handshake occurs when s_valid && s_ready.
  - On a handshake, the next edge registers pl_en=1, pl_wr_en=1, pl_addr=index, pl_din=s_data. Latency is 1 cycle from handshake to BRAM write cycle.
  - Index and word_count increment on each handshake.
  - On cycles without a handshake, the next edge clears pl_en and pl_wr_en to 0. pl_addr and pl_din hold their last value.
  - Back-to-back handshakes give one write per cycle; no bubbles are inserted.
  - The handshake of word DEPTH-1 (index==DEPTH-1) moves to DONE next edge. From that edge, s_ready=0, so at most DEPTH words are accepted.
  - Index wraps to 0 on that handshake. With DEPTH=2^ADDR_W this is natural ADDR_W-bit overflow; otherwise it is an explicit compare-and-clear.
  - start is ignored while in FILL.
- DONE:
  - The write of the final word appears on the BRAM port in the first DONE cycle, coincident with done=1.
  - done stays 1 while in DONE; word_count holds at DEPTH.
  - done_ack=1 moves to IDLE next edge and clears done the same edge. word_count holds its value until the next start.
  - start is ignored while in DONE, including when it arrives in the same cycle as done_ack. The producer must re-assert start in IDLE.
- DEPTH=1: one handshake goes FILL->DONE.
- Arithmetic: word_count is ADDR_W+1 bits so that DEPTH=2^ADDR_W is representable; no saturation logic is needed beyond the DEPTH stop.

Test Plan:
- DEPTH=4, reset, start, then s_valid continuous with data 0xA0..0xA3 -> writes (addr,din) = (0,A0),(1,A1),(2,A2),(3,A3) on 4 consecutive cycles, each 1 cycle after its handshake. done=1 from the cycle of the addr-3 write; s_ready=0 thereafter; word_count=4.
- DEPTH=4, s_valid toggling 1,0,1,0... -> pl_en pulses every other cycle and addresses stay sequential 0..3. No write occurs on s_valid=0 cycles; pl_addr holds between writes.
- In DONE, hold s_valid=1 for 10 cycles, then done_ack=1 together with start=1 -> no writes, done=0 next cycle, state IDLE, busy=0. A later start alone re-enters FILL at addr 0.
- rst_n=0 for 1 cycle after the 2nd of 4 handshakes -> next edge pl_en=0, word_count=0, done=0, s_ready=0. A following start writes from addr 0 again.
- ADDR_W=16, DEPTH=65536, continuous stream of data equal to the address -> last write is addr 0xFFFF and word_count=65536. The next frame starts at addr 0; there is no out-of-range address.
- DEPTH=1: start, single handshake with 0x5 -> one write (0,0x5); done=1 in the same cycle as that write.
